// File: rtl/pipeline_stall_controller.sv
// Central pipeline control for the 5-stage RV32 core: turns hazard, redirect
// and data-memory handshake requests into stage-register enables and flushes,
// inserts data-memory wait states, traps runaway waits and counts events.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_RUN      | pipeline flowing; a MEM access without ready starts a wait
// ST_MEM_WAIT | pipeline frozen on an outstanding data-memory access
// ST_ERROR    | access exceeded MEM_TIMEOUT frozen cycles; only rst exits
module pipeline_stall_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use_stall,
    input  logic             ex_redirect,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             dmem_valid,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    localparam int TMR_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] wait_timer_q, wait_timer_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic freeze;
    logic apply_redirect;
    logic apply_stall;

    // Classify the current cycle by priority: error > freeze > redirect > load-use.
    always_comb begin
        freeze         = 1'b0;
        apply_redirect = 1'b0;
        apply_stall    = 1'b0;
        if (!rst) begin
            freeze = ((state_q == ST_RUN) && mem_access && !dmem_ready) ||
                     ((state_q == ST_MEM_WAIT) && !dmem_ready);
            if (state_q != ST_ERROR && !freeze) begin
                apply_redirect = ex_redirect;
                apply_stall    = !ex_redirect && load_use_stall;
            end
        end
    end

    // Drive stage enables, flushes and the memory strobe with zero latency.
    always_comb begin
        pc_we         = 1'b0;
        if_id_we      = 1'b0;
        id_ex_we      = 1'b0;
        ex_mem_we     = 1'b0;
        mem_wb_we     = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        dmem_valid    = 1'b0;
        if (rst) begin
            // Flush every stage so the pipeline restarts from NOPs.
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (state_q != ST_ERROR) begin
            dmem_valid = mem_access;
            if (freeze) begin
                mem_wb_we     = 1'b1;
                mem_wb_bubble = 1'b1;
            end else if (apply_redirect) begin
                pc_we       = 1'b1;
                if_id_we    = 1'b1;
                id_ex_we    = 1'b1;
                ex_mem_we   = 1'b1;
                mem_wb_we   = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (apply_stall) begin
                id_ex_we    = 1'b1;
                id_ex_flush = 1'b1;
                ex_mem_we   = 1'b1;
                mem_wb_we   = 1'b1;
            end else begin
                pc_we     = 1'b1;
                if_id_we  = 1'b1;
                id_ex_we  = 1'b1;
                ex_mem_we = 1'b1;
                mem_wb_we = 1'b1;
            end
        end
    end

    // Next state, wait timer and sticky timeout flag.
    always_comb begin
        state_d       = state_q;
        wait_timer_d  = wait_timer_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            ST_RUN: begin
                if (mem_access && !dmem_ready) begin
                    state_d      = ST_MEM_WAIT;
                    wait_timer_d = TMR_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d      = ST_RUN;
                    wait_timer_d = '0;
                end else if (wait_timer_q == TMR_LAST) begin
                    state_d       = ST_ERROR;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_timer_d = wait_timer_q + TMR_W'(1);
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d      = ST_RUN;
                wait_timer_d = '0;
            end
        endcase
    end

    // Saturating event counters; they stick at all-ones rather than wrap.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        if (apply_stall && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (apply_redirect && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
        if (freeze && wait_cnt_q != '1) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            wait_timer_q  <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            wait_timer_q  <= wait_timer_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign wait_cnt    = wait_cnt_q;

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Central pipeline-control responder for the 5-stage RV32 core. It consumes the ID-stage load-use stall request, the EX-stage branch/jump redirect and the MEM-stage data-memory handshake, and drives every stage-register write enable and flush. A small FSM adds multi-cycle data-memory wait states, a wait timeout, and saturating performance counters.

## Interface
- MEM_TIMEOUT, 16: maximum consecutive frozen cycles awaiting `dmem_ready` (≥2).
- CNT_W, 32: width of the performance counters.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- load_use_stall  in  1  load-use stall request from the hazard detection unit.
- ex_redirect  in  1  taken branch or jump resolved in EX.
- mem_access  in  1  instruction in MEM performs a load or store.
- dmem_ready  in  1  data memory completes the current access this cycle.
- dmem_valid  out  1  data-memory request strobe.
- pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we  out  1 each  stage-register write enables.
- if_id_flush, id_ex_flush  out  1 each  load NOP into IF/ID, ID/EX.
- mem_wb_bubble  out  1  load NOP into MEM/WB.
- mem_timeout  out  1  sticky error flag.
- stall_cnt, flush_cnt, wait_cnt  out  CNT_W each  saturating counters.

## Operation
- States: RUN, MEM_WAIT, ERROR. Reset state RUN.
- Freeze condition F = (RUN & mem_access & !dmem_ready) | (MEM_WAIT & !dmem_ready).
- Priority, evaluated combinationally each cycle: ERROR > F > ex_redirect > load_use_stall > normal.
- ERROR:
  - All `*_we` = 0 and all flush/bubble = 0.
  - `dmem_valid` = 0, `mem_timeout` = 1.
  - Leaves ERROR only on `rst`.
- F (freeze):
  - `pc_we`/`if_id_we`/`id_ex_we`/`ex_mem_we` = 0.
  - `mem_wb_we` = 1 with `mem_wb_bubble` = 1.
  - Redirect and load-use requests are ignored. Sources hold them because the EX and ID stages are frozen.
- Redirect:
  - All `*_we` = 1, `if_id_flush` = 1, `id_ex_flush` = 1.
  - Suppresses a simultaneous load-use stall, because the ID instruction is on the wrong path.
- Load-use:
  - `pc_we` = 0, `if_id_we` = 0.
  - `id_ex_we` = 1 with `id_ex_flush` = 1.
  - `ex_mem_we` = 1, `mem_wb_we` = 1.
- Normal: all `*_we` = 1, all flush/bubble = 0.
- `dmem_valid` = `mem_access` in RUN and MEM_WAIT, and 0 in ERROR.
- Transitions:
  - RUN→MEM_WAIT when RUN & mem_access & !dmem_ready.
  - MEM_WAIT→RUN when dmem_ready = 1. That cycle is not frozen and the pipeline advances with normal priority.
  - MEM_WAIT→ERROR when !dmem_ready and wait_timer == MEM_TIMEOUT−1.
- wait_timer:
  - Set to 1 on the RUN→MEM_WAIT edge.
  - Incremented each MEM_WAIT cycle with !dmem_ready.
  - Net effect: MEM_TIMEOUT consecutive frozen cycles without `dmem_ready` force ERROR.
- Zero-wait access: RUN & mem_access & dmem_ready causes no freeze and no state change.
- Counters, each saturating at 2^CNT_W−1 and never wrapping:
  - `stall_cnt` +1 per cycle in which a load-use bubble is applied.
  - `flush_cnt` +1 per applied redirect.
  - `wait_cnt` +1 per frozen cycle.

## Timing
- All outputs except the counters and `mem_timeout` are combinational from state and inputs, with zero latency.
- Counters, timer, state and `mem_timeout` update on the clk edge.
- While `rst` = 1, regardless of state:
  - All `*_we` = 0.
  - `if_id_flush` = `id_ex_flush` = `mem_wb_bubble` = 1.
  - `dmem_valid` = 0.
  - Registers load state = RUN, counters = 0, timer = 0, `mem_timeout` = 0.
- The first cycle after reset behaves as RUN.
- Reset in MEM_WAIT or ERROR abandons the access. No `dmem_valid` is issued during reset.
- A freeze ending and a redirect pending in the same cycle: the redirect is applied in the cycle `dmem_ready` = 1.

## Test plan
- Reset, then idle inputs → all `*_we` = 1, flushes 0, counters 0, state RUN.
- `load_use_stall` = 1 for 1 cycle → `pc_we` = 0, `if_id_we` = 0, `id_ex_flush` = 1, `ex_mem_we` = 1; `stall_cnt` = 1 next cycle.
- `ex_redirect` = 1 and `load_use_stall` = 1 together → `pc_we` = 1, `if_id_flush` = `id_ex_flush` = 1; `flush_cnt` = 1, `stall_cnt` = 0.
- `mem_access` = 1, `dmem_ready` low for 3 cycles then high, `ex_redirect` = 1 throughout:
  - 3 frozen cycles with `mem_wb_bubble` = 1 and `dmem_valid` = 1.
  - 4th cycle advances with redirect flush.
  - Result: `wait_cnt` = 3, `flush_cnt` = 1, state RUN.
- MEM_TIMEOUT = 4, `mem_access` = 1, `dmem_ready` never → 4 frozen cycles; 5th cycle in ERROR with `mem_timeout` = 1, all enables 0, `dmem_valid` = 0; `rst` clears to RUN.
- CNT_W = 3, `load_use_stall` held 10 cycles → `stall_cnt` reaches 7 and stays 7.
